// File: rtl/coproc_pkg.sv
// coproc_pkg: shared types and constants for the coprocessor memory arbiter
package coproc_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    REQ      = 3'b010,
    WAIT_RES = 3'b100
  } arb_state_e;
  localparam logic [2:0] MEM_SIZE_WORD = 3'h2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at last_i+1 mod NUM_REQ
// Ports: req_i request vector, last_i previous winner, gnt_o one-hot grant, idx_o winner index
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  logic [IW-1:0] w_cand;
  // Scan from the farthest candidate down to the nearest so the nearest requester wins.
  always_comb begin
    idx_o  = '0;
    w_cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = IW'((int'(last_i) + i) % NUM_REQ);
      if (req_i[w_cand]) idx_o = w_cand;
    end
    gnt_o = (|req_i) ? (NUM_REQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/coproc_mem_arbiter.sv
// coproc_mem_arbiter: shares one XIF mem channel among NUM_REQ coprocessors, one transaction in flight
// Ports: clk_i/rst_ni (sync, active-low); req_* per-requester request side (packed, requester 0 in LSBs);
//   mem_* core-side request; mem_result_* core-side result; rsp_* registered response (one-hot valid);
//   id_mismatch_o pulses for any result that does not complete the current transaction.
// Optional: define COPROC_MEM_ARB_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog on the result wait.
module coproc_mem_arbiter
  import coproc_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int X_ID_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*X_ID_WIDTH-1:0] req_id_i,
  input  logic [NUM_REQ*32-1:0]         req_addr_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*4-1:0]          req_be_i,
  input  logic [NUM_REQ*32-1:0]         req_wdata_i,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic [X_ID_WIDTH-1:0]         mem_id_o,
  output logic [31:0]                   mem_addr_o,
  output logic                          mem_we_o,
  output logic [3:0]                    mem_be_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [2:0]                    mem_size_o,
  input  logic                          mem_result_valid_i,
  input  logic [X_ID_WIDTH-1:0]         mem_result_id_i,
  input  logic [31:0]                   mem_result_rdata_i,
  input  logic                          mem_result_err_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [31:0]                   rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          id_mismatch_o
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_e              r_state, w_next;
  logic [IW-1:0]           r_last, w_idx;
  logic [NUM_REQ-1:0]      w_gnt, r_rsp_valid;
  logic [X_ID_WIDTH-1:0]   r_id;
  logic [31:0]             r_addr, r_wdata, r_rsp_rdata;
  logic [3:0]              r_be;
  logic                    r_we, r_rsp_err, r_mismatch;
  logic                    w_accept, w_hit, w_to, w_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req_i  (req_valid_i),
    .last_i (r_last),
    .gnt_o  (w_gnt),
    .idx_o  (w_idx)
  );

  assign w_accept = (r_state == IDLE) && (|req_valid_i);
  assign w_hit    = (r_state == WAIT_RES) && mem_result_valid_i && (mem_result_id_i == r_id);
  assign w_done   = w_hit || w_to;

`ifdef COPROC_MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  // Counter is 0 on the first WAIT_RES cycle, so the pulse lands TIMEOUT_CYCLES cycles after entry.
  assign w_to = (r_state == WAIT_RES) && !w_hit && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_cnt <= '0;
    else         r_cnt <= (r_state == WAIT_RES) ? r_cnt + CW'(1) : '0;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_to = 1'b0;
`endif

  always_comb begin
    w_next = (r_state == IDLE && |req_valid_i)  ? REQ      :
             (r_state == REQ && mem_ready_i)    ? WAIT_RES :
             w_done                             ? IDLE     : r_state;
  end

  // r_last doubles as the owner of the in-flight transaction.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_last      <= IW'(NUM_REQ - 1);
      r_id        <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last  <= w_idx;
        r_id    <= req_id_i[int'(w_idx)*X_ID_WIDTH +: X_ID_WIDTH];
        r_addr  <= req_addr_i[int'(w_idx)*32 +: 32];
        r_we    <= req_we_i[w_idx];
        r_be    <= req_be_i[int'(w_idx)*4 +: 4];
        r_wdata <= req_wdata_i[int'(w_idx)*32 +: 32];
      end
      r_rsp_valid <= w_done ? (NUM_REQ'(1) << r_last) : '0;
      r_rsp_rdata <= w_hit ? mem_result_rdata_i : '0;
      r_rsp_err   <= w_hit ? mem_result_err_i : w_to;
      r_mismatch  <= mem_result_valid_i && !w_hit;
    end
  end

  assign req_ready_o   = (r_state == IDLE) ? w_gnt : '0;
  assign mem_valid_o   = (r_state == REQ);
  assign mem_id_o      = r_id;
  assign mem_addr_o    = r_addr;
  assign mem_we_o      = r_we;
  assign mem_be_o      = r_be;
  assign mem_wdata_o   = r_wdata;
  assign mem_size_o    = MEM_SIZE_WORD;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign id_mismatch_o = r_mismatch;
endmodule

// File: tb/tb_coproc_mem_arbiter.sv
// tb_coproc_mem_arbiter: randomized transaction-level check of coproc_mem_arbiter against a scoreboard
module tb_coproc_mem_arbiter;
  localparam int N = 3, IDW = 4, TO = 8;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;
  logic [N-1:0] req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
  logic [N*IDW-1:0] req_id_i;
  logic [N*32-1:0] req_addr_i, req_wdata_i;
  logic [N*4-1:0] req_be_i;
  logic mem_valid_o, mem_ready_i, mem_we_o, mem_result_valid_i, mem_result_err_i, rsp_err_o, id_mismatch_o;
  logic [IDW-1:0] mem_id_o, mem_result_id_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_result_rdata_i, rsp_rdata_o;
  logic [3:0] mem_be_o;
  logic [2:0] mem_size_o;

  coproc_mem_arbiter #(.NUM_REQ(N), .X_ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_id_i(req_id_i), .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_be_i(req_be_i),
    .req_wdata_i(req_wdata_i), .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_id_o(mem_id_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o), .mem_result_valid_i(mem_result_valid_i),
    .mem_result_id_i(mem_result_id_i), .mem_result_rdata_i(mem_result_rdata_i),
    .mem_result_err_i(mem_result_err_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .id_mismatch_o(id_mismatch_o)
  );

  int n_tests = 0, n_fail = 0;
  logic [N-1:0] pend;
  logic [IDW-1:0] p_id [N];
  logic [31:0] p_addr [N], p_wdata [N];
  logic p_we [N];
  logic [3:0] p_be [N];
  int last_g;
  logic [N-1:0] exp_rsp;
  logic [31:0] exp_rdata;
  logic exp_err, exp_mm;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] p);
    for (int i = 1; i <= N; i++) if (p[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic new_req(input int r);
    pend[r] = 1'b1; p_id[r] = IDW'($urandom); p_addr[r] = $urandom; p_wdata[r] = $urandom;
    p_we[r] = 1'($urandom_range(1)); p_be[r] = 4'($urandom);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = pend[i]; req_we_i[i] = p_we[i];
      req_id_i[i*IDW +: IDW] = p_id[i]; req_addr_i[i*32 +: 32] = p_addr[i];
      req_wdata_i[i*32 +: 32] = p_wdata[i]; req_be_i[i*4 +: 4] = p_be[i];
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    check("rsp_valid", rsp_valid_o, exp_rsp);
    check("id_mismatch", id_mismatch_o, exp_mm);
    if (exp_rsp != 0) begin
      check("rsp_rdata", rsp_rdata_o, exp_rdata);
      check("rsp_err", rsp_err_o, exp_err);
    end
    exp_rsp = '0; exp_mm = 1'b0;
    mem_ready_i = 1'b0; mem_result_valid_i = 1'b0; mem_result_id_i = '0;
    mem_result_rdata_i = '0; mem_result_err_i = 1'b0;
    drive();
  endtask

  // Called on an IDLE cycle; returns positioned on the next IDLE cycle.
  task automatic txn(input int mode, input int rdly, input int sdly, input bit bad,
                     input bit stray, input bit rst, input bit tmo, input logic [31:0] rd);
    int w;
    logic [IDW-1:0] o_id;
    logic [31:0] o_addr, o_wd;
    logic o_we, e;
    logic [3:0] o_be;
    for (int i = 0; i < N; i++)
      if (!pend[i] && (mode == 2 || (mode == 1 && $urandom_range(1) == 1))) new_req(i);
    if (pend == '0) new_req($urandom_range(N - 1));
    drive();
    #1;
    w = rr_pick(last_g, pend);
    check("req_ready", req_ready_o, N'(1) << w);
    check("mem_valid_idle", mem_valid_o, 0);
    o_id = p_id[w]; o_addr = p_addr[w]; o_wd = p_wdata[w]; o_we = p_we[w]; o_be = p_be[w];
    pend[w] = 1'b0; last_g = w;
    for (int k = 0; k <= rdly; k++) begin
      step();
      mem_ready_i = (k == rdly);
      if (stray && k == rdly) begin
        mem_result_valid_i = 1'b1; mem_result_id_i = o_id; exp_mm = 1'b1;
      end
      #1;
      check("mem_valid", mem_valid_o, 1);
      check("mem_addr", mem_addr_o, o_addr);
      check("mem_wdata", mem_wdata_o, o_wd);
      check("mem_be", mem_be_o, o_be);
      check("mem_we", mem_we_o, o_we);
      check("mem_id", mem_id_o, o_id);
      check("mem_size", mem_size_o, 3'h2);
      check("req_ready_busy", req_ready_o, 0);
    end
    if (rst) begin
      step();
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      last_g = N - 1;
      check("rst_mem_valid", mem_valid_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_id", mem_id_o, 0);
      check("rst_mem_wdata", mem_wdata_o, 0);
      check("rst_rsp_rdata", rsp_rdata_o, 0);
      check("rst_rsp_err", rsp_err_o, 0);
      return;
    end
    if (tmo) begin
`ifdef COPROC_MEM_ARB_TIMEOUT_EN
      for (int k = 1; k <= TO; k++) begin
        step();
        #1 check("mem_valid_to", mem_valid_o, 0);
        if (k == TO) begin exp_rsp = N'(1) << w; exp_rdata = '0; exp_err = 1'b1; end
      end
      step();
      mem_result_valid_i = 1'b1; mem_result_id_i = o_id; exp_mm = 1'b1;
      return;
`endif
    end
    for (int k = 0; k <= sdly; k++) begin
      step();
      if (k == sdly) begin
        e = (mode == 1) ? 1'($urandom_range(1)) : 1'b0;
        mem_result_valid_i = 1'b1; mem_result_id_i = o_id; mem_result_rdata_i = rd;
        mem_result_err_i = e; exp_rsp = N'(1) << w; exp_rdata = rd; exp_err = e;
      end else if (bad && k == 0) begin
        mem_result_valid_i = 1'b1; mem_result_id_i = o_id ^ IDW'(6);
        mem_result_rdata_i = $urandom; exp_mm = 1'b1;
      end
      #1;
      check("mem_valid_wait", mem_valid_o, 0);
      check("req_ready_wait", req_ready_o, 0);
    end
    step();
  endtask

  initial begin
    int sd;
    pend = '0; last_g = N - 1; exp_rsp = '0; exp_mm = 1'b0; exp_rdata = '0; exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_id[i] = '0; p_addr[i] = '0; p_wdata[i] = '0; p_we[i] = 1'b0; p_be[i] = '0;
    end
    mem_ready_i = 1'b0; mem_result_valid_i = 1'b0; mem_result_id_i = '0;
    mem_result_rdata_i = '0; mem_result_err_i = 1'b0;
    drive();
    repeat (2) @(negedge clk_i);
    check("reset_mem_valid", mem_valid_o, 0);
    check("reset_rsp_valid", rsp_valid_o, 0);
    check("reset_mismatch", id_mismatch_o, 0);
    check("reset_mem_addr", mem_addr_o, 0);
    check("reset_req_ready", req_ready_o, 0);
    check("reset_mem_size", mem_size_o, 3'h2);
    rst_ni = 1'b1;
    // single write from requester 0
    pend[0] = 1'b1; p_id[0] = 4'd3; p_addr[0] = 32'h1000; p_wdata[0] = 32'hCAFEF00D;
    p_be[0] = 4'hF; p_we[0] = 1'b1;
    txn(0, 0, 0, 0, 0, 0, 0, $urandom);
    // all requesters continuously valid: strict rotation
    repeat (6) txn(2, 0, 0, 0, 0, 0, 0, $urandom);
    // backpressure for 5 cycles
    txn(1, 5, 1, 0, 0, 0, 0, $urandom);
    // wrong id 5 before the owner's id 3 result
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) new_req(i);
      p_id[i] = 4'd3;
    end
    txn(0, 0, 2, 1, 0, 0, 0, 32'h12345678);
    // result coincident with mem_ready is ignored
    txn(1, 1, 1, 0, 1, 0, 0, $urandom);
    // reset while waiting for the result, then requester 0 wins
    txn(1, 0, 0, 0, 0, 1, 0, $urandom);
    if (!pend[0]) new_req(0);
    txn(0, 0, 0, 0, 0, 0, 0, $urandom);
`ifdef COPROC_MEM_ARB_TIMEOUT_EN
    txn(1, 0, 0, 0, 0, 0, 1, '0);
`endif
    repeat (40) begin
      sd = $urandom_range(3);
      txn(1, $urandom_range(3), sd, (sd > 0) && ($urandom_range(1) == 1),
          $urandom_range(3) == 0, 0, 0, $urandom);
    end
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/coproc_mem_arbiter.md
# coproc_mem_arbiter

Shares the single eXtension-interface memory channel (mem / mem_result) of the cv32e40x core between NUM_REQ coprocessor memory requesters. Arbitration is round-robin, and only one transaction is outstanding at a time. The block sits between the custom coprocessors and the core-side `cv32e40x_if_xif` mem ports. It holds the core-facing request stable until it is accepted, then routes the matching result back to the requester that owns it.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (2..8)
- X_ID_WIDTH, 4: width of the offload instruction ID
- TIMEOUT_CYCLES, 64: watchdog limit for the result wait; used only with the watchdog compiled in

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept pulse (combinational)
- req_id_i  in  NUM_REQ*X_ID_WIDTH  instruction ID, packed, requester 0 in the LSBs
- req_addr_i  in  NUM_REQ*32  byte address
- req_we_i  in  NUM_REQ  write enable
- req_be_i  in  NUM_REQ*4  byte enables
- req_wdata_i  in  NUM_REQ*32  write data
- mem_valid_o  out  1  core-side request valid
- mem_ready_i  in  1  core-side request accept
- mem_id_o  out  X_ID_WIDTH  request ID
- mem_addr_o  out  32  address
- mem_we_o  out  1  write enable
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  write data
- mem_size_o  out  3  transfer size; constant 3'h2 (word)
- mem_result_valid_i  in  1  result valid
- mem_result_id_i  in  X_ID_WIDTH  result ID
- mem_result_rdata_i  in  32  read data
- mem_result_err_i  in  1  bus error
- rsp_valid_o  out  NUM_REQ  one-hot response pulse
- rsp_rdata_o  out  32  response read data, shared by all requesters
- rsp_err_o  out  1  response error, shared by all requesters
- id_mismatch_o  out  1  one-cycle pulse on an unexpected result

## Operation
The block is a three-state FSM: IDLE, REQ, WAIT_RES.

- **IDLE**
  - If any req_valid_i is set, select the winner round-robin, starting at last_grant+1 modulo NUM_REQ.
  - Assert req_ready_o[winner] in the same cycle.
  - Register the winner's payload, the owner index and last_grant, then go to REQ.
- **REQ**
  - Drive mem_valid_o=1 with the registered payload.
  - The payload must not change while mem_valid_o=1 and mem_ready_i=0.
  - When mem_ready_i=1, go to WAIT_RES.
- **WAIT_RES**
  - When mem_result_valid_i=1 and mem_result_id_i equals the owner's ID:
    - in the next cycle, pulse rsp_valid_o[owner] for one cycle;
    - in that same cycle, drive rsp_rdata_o and rsp_err_o from the result;
    - go to IDLE.
  - When mem_result_valid_i=1 with a different ID: pulse id_mismatch_o the next cycle and stay in WAIT_RES.
- **Results outside WAIT_RES**: ignored, including a result in the same cycle as mem_ready_i. id_mismatch_o pulses.
- **Requesters**: each requester keeps req_valid_i and its payload stable until it sees its req_ready_o pulse.
- **Reset values**:
  - all outputs 0;
  - last_grant = NUM_REQ-1, so requester 0 wins first;
  - state IDLE;
  - mem_size_o is always 3'h2.
- **Reset asserted mid-transaction**: the block returns to IDLE on the next clock edge and the in-flight response is dropped.

## Timing
- Request accepted in cycle 0 (req_ready_o high).
- mem_valid_o rises in cycle 1.
- With mem_ready_i=1 in cycle 1, WAIT_RES starts in cycle 2.
- Earliest result is in cycle 2, giving rsp_valid_o in cycle 3.
- The next request can be accepted in cycle 3 (IDLE).
- Best case is one transaction per 3 cycles.
- rsp_* and id_mismatch_o are registered. req_ready_o is combinational from state and req_valid_i.

## Configuration
- `COPROC_MEM_ARB_TIMEOUT_EN` defined:
  - a cycle counter runs in WAIT_RES;
  - when it reaches TIMEOUT_CYCLES without a matching result, pulse rsp_valid_o[owner] with rsp_err_o=1 and rsp_rdata_o=0, then go to IDLE;
  - a result that arrives after the timeout counts as a mismatch (id_mismatch_o).
- Undefined: no counter; WAIT_RES waits indefinitely.

## Structure
- coproc_pkg gains:
  - `arb_state_e`: IDLE=3'b001, REQ=3'b010, WAIT_RES=3'b100 (one-hot);
  - `MEM_SIZE_WORD = 3'h2`.
- Sub-module `rr_arbiter` takes the request vector and last_grant, and returns a one-hot grant plus the winner index. It is purely combinational.
- The FSM, payload registers and watchdog live in coproc_mem_arbiter.

## Test plan
- **Single write**: req 0 with addr 0x1000, wdata 0xCAFEF00D, be 4'hF, id 3; mem_ready_i in cycle 1; result id 3, err 0 in cycle 2 -> mem_addr_o=0x1000 in cycle 1, rsp_valid_o=2'b01 in cycle 3.
- **Round-robin**: both requesters valid continuously -> grant order 0,1,0,1; no requester is starved.
- **Backpressure**: mem_ready_i held low for 5 cycles -> mem_valid_o high and the payload is bit-stable for all 6 cycles.
- **ID mismatch**: result id 5 while the owner's id is 3 -> id_mismatch_o pulses; the block stays in WAIT_RES; a later id-3 result completes normally with rdata 0x12345678.
- **Timeout** (macro on, TIMEOUT_CYCLES=8): no result -> rsp_valid_o and rsp_err_o=1 exactly 8 cycles after WAIT_RES is entered; the block returns to IDLE.
- **Reset in WAIT_RES**: rst_ni low for one cycle -> all outputs 0 and no rsp_valid_o; the next request is granted to requester 0.
